// File: rtl/tlb_op_seq.sv
// Sequencer for the privileged TLB instructions: drives the TLB array search/read/write ports
// one op at a time and produces the TLBIDX update strobes. INVTLB walks every entry.
module tlb_op_seq #(
  parameter int TLB_NUM = 64,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [4:0]       inv_op,
  input  logic [9:0]       inv_asid,
  input  logic [18:0]      inv_va,
  output logic             op_ready,
  output logic             op_done,
  output logic             op_err,
  input  logic [IDX_W-1:0] csr_index,
  input  logic [9:0]       csr_asid,
  input  logic [18:0]      csr_vppn,
  output logic             srch_req,
  output logic [18:0]      srch_vppn,
  output logic [9:0]       srch_asid,
  input  logic             srch_hit,
  input  logic [IDX_W-1:0] srch_idx,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_idx,
  input  logic             rd_e,
  input  logic             rd_g,
  input  logic [5:0]       rd_ps,
  input  logic [9:0]       rd_asid,
  input  logic [18:0]      rd_vppn,
  output logic             we,
  output logic [IDX_W-1:0] w_idx,
  output logic             w_clear,
  output logic             tlbsrch_hit,
  output logic             tlbsrch_miss,
  output logic [IDX_W-1:0] tlb_hit_idx,
  output logic             tlbrd_en,
  output logic [5:0]       tlb_ps,
  output logic             tlb_e
);
  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_SRCH_REQ, S_SRCH_CAP, S_RD_REQ, S_RD_CAP,
    S_WRITE, S_INV_RD, S_INV_CMP, S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [2:0]       r_op, r_inv_op;
  logic [9:0]       r_inv_asid, r_asid;
  logic [18:0]      r_inv_va, r_vppn;
  logic [IDX_W-1:0] r_idx, r_fill, r_cnt, r_cap_idx;
  logic             r_err, r_cap_hit, r_cap_e;
  logic [5:0]       r_cap_ps;
  logic             w_accept, w_illegal, w_last, w_match, w_m_asid, w_m_va;

  assign w_accept  = op_valid && (r_state == S_IDLE);
  assign w_illegal = (op_code > OP_INV) || ((op_code == OP_INV) && (inv_op > 5'd6));
  assign w_last    = (r_cnt == IDX_W'(TLB_NUM - 1));
  assign w_m_asid  = (rd_asid == r_inv_asid);
  assign w_m_va    = (rd_vppn == r_inv_va);

  // Illegal inv_op never reaches the scan, so only the low three bits are kept.
  always_comb begin
    w_match = 1'b0;
    case (r_inv_op)
      3'd0, 3'd1: w_match = 1'b1;
      3'd2:       w_match = rd_g;
      3'd3:       w_match = !rd_g;
      3'd4:       w_match = !rd_g && w_m_asid;
      3'd5:       w_match = !rd_g && w_m_asid && w_m_va;
      3'd6:       w_match = (rd_g || w_m_asid) && w_m_va;
      default:    w_match = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_inv_op   <= '0;
      r_inv_asid <= '0;
      r_inv_va   <= '0;
      r_asid     <= '0;
      r_vppn     <= '0;
      r_idx      <= '0;
      r_fill     <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_cap_hit  <= 1'b0;
      r_cap_idx  <= '0;
      r_cap_ps   <= '0;
      r_cap_e    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fill  <= r_fill + 1'b1;
      if (w_accept) begin
        r_op       <= op_code;
        r_inv_op   <= inv_op[2:0];
        r_inv_asid <= inv_asid;
        r_inv_va   <= inv_va;
        r_asid     <= csr_asid;
        r_vppn     <= csr_vppn;
        r_idx      <= (op_code == OP_FILL) ? r_fill : csr_index;
        r_err      <= w_illegal;
        r_cnt      <= '0;
      end
      if (r_state == S_INV_CMP) r_cnt <= r_cnt + 1'b1;
      if (r_state == S_SRCH_CAP) begin
        r_cap_hit <= srch_hit;
        r_cap_idx <= srch_idx;
      end
      if (r_state == S_RD_CAP) begin
        r_cap_ps <= rd_ps;
        r_cap_e  <= rd_e;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    op_ready     = 1'b0;
    op_done      = 1'b0;
    op_err       = 1'b0;
    srch_req     = 1'b0;
    srch_vppn    = '0;
    srch_asid    = '0;
    rd_en        = 1'b0;
    rd_idx       = '0;
    we           = 1'b0;
    w_idx        = '0;
    w_clear      = 1'b0;
    tlbsrch_hit  = 1'b0;
    tlbsrch_miss = 1'b0;
    tlb_hit_idx  = '0;
    tlbrd_en     = 1'b0;
    tlb_ps       = '0;
    tlb_e        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (op_valid) begin
          if (w_illegal) w_next = S_DONE;
          else begin
            case (op_code)
              OP_SRCH:       w_next = S_SRCH_REQ;
              OP_RD:         w_next = S_RD_REQ;
              OP_WR, OP_FILL: w_next = S_WRITE;
              default:       w_next = S_INV_RD;
            endcase
          end
        end
      end
      S_SRCH_REQ: begin
        srch_req  = 1'b1;
        srch_vppn = r_vppn;
        srch_asid = r_asid;
        w_next    = S_SRCH_CAP;
      end
      S_SRCH_CAP: w_next = S_DONE;
      S_RD_REQ: begin
        rd_en  = 1'b1;
        rd_idx = r_idx;
        w_next = S_RD_CAP;
      end
      S_RD_CAP: w_next = S_DONE;
      S_WRITE: begin
        we     = 1'b1;
        w_idx  = r_idx;
        w_next = S_DONE;
      end
      S_INV_RD: begin
        rd_en  = 1'b1;
        rd_idx = r_cnt;
        w_next = S_INV_CMP;
      end
      S_INV_CMP: begin
        if (w_match) begin
          we      = 1'b1;
          w_clear = 1'b1;
          w_idx   = r_cnt;
        end
        w_next = w_last ? S_DONE : S_INV_RD;
      end
      S_DONE: begin
        op_done = 1'b1;
        op_err  = r_err;
        if (!r_err && r_op == OP_SRCH) begin
          tlbsrch_hit  = r_cap_hit;
          tlbsrch_miss = !r_cap_hit;
          tlb_hit_idx  = r_cap_hit ? r_cap_idx : '0;
        end
        if (!r_err && r_op == OP_RD) begin
          tlbrd_en = 1'b1;
          tlb_ps   = r_cap_ps;
          tlb_e    = r_cap_e;
        end
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule
